// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
package hilo_pkg;

    // Operation encodings as presented on the op input.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Iteration counter must hold values 0..xlen.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative datapath: 2*XLEN accumulator doing one shift-add (multiply)
// or one restoring-subtract (divide) step per enabled cycle on magnitudes.
module hilo_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem;
    logic [XLEN:0]     div_diff;

    // Multiply: low half holds remaining multiplier bits, high half the partial
    // product; carry of the add is kept by shifting the XLEN+1 bit sum in.
    // Divide: high half is the partial remainder, low half shifts dividend
    // bits out and quotient bits in. The remainder stays below the divisor,
    // so the XLEN+1 bit difference never overflows into its sign bit.
    always_comb begin
        acc_d    = acc_q;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        div_rem  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_rem - {1'b0, b_q};
        if (div_mode) begin
            if (div_diff[XLEN])
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            if (acc_q[0])
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            else
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Accumulator and operand register; load has priority over step.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= {{XLEN{1'b0}}, a};
            b_q   <= b;
        end else if (step) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU sequencer and
// the front-end stall for consumers of HI/LO while the unit is busy.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int         XLEN  = 32,
    parameter logic [2:0] SI_HI = 3'b010,
    parameter logic [2:0] SI_LO = 3'b011
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      si,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int CNT_W = cnt_width(XLEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              negq_q, negq_d;   // negate product / quotient
    logic              negr_q, negr_d;   // negate remainder (dividend sign)
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              core_load, core_step;
    logic [2*XLEN-1:0] core_acc;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_abs, rt_abs;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   quo, rem;

    // Only the signed ops (low op bit clear) take magnitudes.
    assign rs_neg   = ~op[0] & rs_val[XLEN-1];
    assign rt_neg   = ~op[0] & rt_val[XLEN-1];
    assign rs_abs   = rs_neg ? -rs_val : rs_val;
    assign rt_abs   = rt_neg ? -rt_val : rt_val;
    assign prod_neg = -core_acc;
    assign quo      = core_acc[XLEN-1:0];
    assign rem      = core_acc[2*XLEN-1:XLEN];

    hilo_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .div_mode (div_q),
        .a        (rs_abs),
        .b        (rt_abs),
        .acc      (core_acc)
    );

    // Next state, datapath control and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start wins over a simultaneous MTHI/MTLO
                    core_load = 1'b1;
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    div_d     = op[1];
                    negq_d    = rs_neg ^ rt_neg;
                    negr_d    = rs_neg;
                    dz_d      = op[1] & (rt_val == '0);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            ST_RUN: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // divide-by-zero: remainder path already yields rs_val
                    lo_d = dz_q ? '1 : (negq_q ? -quo : quo);
                    hi_d = negr_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = negq_q ? prod_neg : core_acc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Operation context, HI/LO and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = busy & ((si == SI_HI) | (si == SI_LO) | start | mthi | mtlo);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;

endmodule
